// File: rtl/regfile_wb_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_sched
//  Purpose  : Arbitrates the integer register-file write port between the
//             in-order pipeline writeback and an out-of-order long-latency
//             unit. Keeps a per-register busy scoreboard, an outstanding-op
//             counter, a one-entry result buffer and a starvation timer that
//             forces issue bubbles so a buffered result eventually drains.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int XLEN        = 64,
  parameter int E_SUPPORTED = 0,
  parameter int MAXPEND     = 4,
  parameter int STARVE      = 4
) (
  input  logic            clk,
  input  logic            reset,
  // issue stage
  input  logic            IssueValid,
  input  logic [4:0]      IssueRs1,
  input  logic [4:0]      IssueRs2,
  input  logic [4:0]      IssueRd,
  input  logic            IssueLong,
  output logic            IssueStall,
  // pipeline writeback (never stalls)
  input  logic            PipeWe,
  input  logic [4:0]      PipeRd,
  input  logic [XLEN-1:0] PipeWd,
  // long-latency result offer
  input  logic            LongValid,
  input  logic [4:0]      LongRd,
  input  logic [XLEN-1:0] LongWd,
  output logic            LongReady,
  // register-file write port
  output logic            RfWe,
  output logic [4:0]      RfA3,
  output logic [XLEN-1:0] RfWd
);

  // Register count covered by the scoreboard (RV32E uses only x0..x15).
  localparam int c_NUMREGS = (E_SUPPORTED != 0) ? 16 : 32;
  localparam int c_PW      = $clog2(MAXPEND + 1);
  localparam int c_WW      = $clog2(STARVE + 1);

  localparam logic [c_PW-1:0] c_MAXPEND = c_PW'(MAXPEND);
  localparam logic [c_PW-1:0] c_PONE    = c_PW'(1);
  localparam logic [c_WW-1:0] c_STARVE  = c_WW'(STARVE);
  localparam logic [c_WW-1:0] c_WONE    = c_WW'(1);

  // A register is tracked when it is not x0 and exists in this configuration.
  function automatic logic f_tracked(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < c_NUMREGS);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]     r_busy;
  logic [c_PW-1:0] r_pend;
  logic            r_buf_full;
  logic [4:0]      r_buf_rd;
  logic [XLEN-1:0] r_buf_wd;
  logic [c_WW-1:0] r_wait;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic       w_pipe_wr;
  logic       w_long_ready;
  logic       w_long_acc;
  logic       w_capture;
  logic       w_drain;
  logic       w_direct;
  logic       w_acc_x0;
  logic       w_complete;
  logic [4:0] w_complete_rd;
  logic       w_hazard;
  logic       w_pend_full;
  logic       w_starve;
  logic       w_stall;
  logic       w_fire_long;

  // Port ownership, acceptance and completion events for this cycle.
  always_comb begin
    w_pipe_wr     = PipeWe & (PipeRd != 5'd0);
    w_long_ready  = ~reset & ~r_buf_full;
    w_long_acc    = LongValid & w_long_ready;
    // x0 results never need the port, so they are never buffered.
    w_capture     = w_long_acc & w_pipe_wr & (LongRd != 5'd0);
    w_drain       = ~reset & r_buf_full & ~w_pipe_wr;
    w_direct      = w_long_acc & ~w_pipe_wr;
    w_acc_x0      = w_long_acc & (LongRd == 5'd0);
    // Drain requires a full buffer, which blocks acceptance, so at most one
    // long op can complete per cycle.
    w_complete    = w_drain | w_direct | w_acc_x0;
    w_complete_rd = w_drain ? r_buf_rd : LongRd;
  end

  // Issue hazard detection and stall generation from registered state only.
  always_comb begin
    w_hazard    = IssueValid & (r_busy[IssueRs1] | r_busy[IssueRs2] | r_busy[IssueRd]);
    w_pend_full = (r_pend == c_MAXPEND);
    w_starve    = (r_wait >= c_STARVE);
    w_stall     = reset | w_hazard | (IssueValid & IssueLong & w_pend_full) | w_starve;
    w_fire_long = IssueValid & ~w_stall & IssueLong;
  end

  // Write-port mux: pipeline first, then buffered result, then direct result.
  always_comb begin
    RfWe = 1'b0;
    RfA3 = 5'd0;
    RfWd = '0;
    if (!reset) begin
      if (w_pipe_wr) begin
        RfWe = 1'b1;
        RfA3 = PipeRd;
        RfWd = PipeWd;
      end else if (r_buf_full) begin
        RfWe = 1'b1;
        RfA3 = r_buf_rd;
        RfWd = r_buf_wd;
      end else if (LongValid && (LongRd != 5'd0)) begin
        RfWe = 1'b1;
        RfA3 = LongRd;
        RfWd = LongWd;
      end
    end
  end

  assign IssueStall = w_stall;
  assign LongReady  = w_long_ready;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------

  // Busy scoreboard: set on long issue, cleared on completion (never the same reg).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_complete && f_tracked(w_complete_rd))
        r_busy[w_complete_rd] <= 1'b0;
      if (w_fire_long && f_tracked(IssueRd))
        r_busy[IssueRd] <= 1'b1;
    end
  end

  // Outstanding long-op count; untracked destinations are counted too.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      case ({w_fire_long, w_complete})
        2'b10:   r_pend <= r_pend + c_PONE;
        2'b01:   r_pend <= r_pend - c_PONE;
        default: r_pend <= r_pend;
      endcase
    end
  end

  // One-entry result buffer: filled when the pipe owns the port, emptied on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_buf_rd   <= 5'd0;
      r_buf_wd   <= '0;
    end else if (w_capture) begin
      r_buf_full <= 1'b1;
      r_buf_rd   <= LongRd;
      r_buf_wd   <= LongWd;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  // Starvation timer: counts cycles a buffered result is held off, saturating.
  always_ff @(posedge clk) begin
    if (reset || !r_buf_full || w_drain) begin
      r_wait <= '0;
    end else if (!w_starve) begin
      r_wait <= r_wait + c_WONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_sched
//  Purpose  : Self-checking bench for regfile_wb_sched. A queue/array based
//             reference model is compared against every output on every
//             falling edge; directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

  localparam int XLEN  = 64;
  localparam int E_SUP = 1;
  localparam int MAXP  = 4;
  localparam int STV   = 4;
  localparam int NREG  = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            IssueValid = 1'b0;
  logic [4:0]      IssueRs1 = '0, IssueRs2 = '0, IssueRd = '0;
  logic            IssueLong = 1'b0;
  logic            IssueStall;
  logic            PipeWe = 1'b0;
  logic [4:0]      PipeRd = '0;
  logic [XLEN-1:0] PipeWd = '0;
  logic            LongValid = 1'b0;
  logic [4:0]      LongRd = '0;
  logic [XLEN-1:0] LongWd = '0;
  logic            LongReady;
  logic            RfWe;
  logic [4:0]      RfA3;
  logic [XLEN-1:0] RfWd;

  always #5 clk = ~clk;

  regfile_wb_sched #(
    .XLEN(XLEN), .E_SUPPORTED(E_SUP), .MAXPEND(MAXP), .STARVE(STV)
  ) dut (
    .clk(clk), .reset(reset),
    .IssueValid(IssueValid), .IssueRs1(IssueRs1), .IssueRs2(IssueRs2),
    .IssueRd(IssueRd), .IssueLong(IssueLong), .IssueStall(IssueStall),
    .PipeWe(PipeWe), .PipeRd(PipeRd), .PipeWd(PipeWd),
    .LongValid(LongValid), .LongRd(LongRd), .LongWd(LongWd), .LongReady(LongReady),
    .RfWe(RfWe), .RfA3(RfA3), .RfWd(RfWd)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } res_t;

  bit         mbusy [32];
  int         mpend;
  int         mwait;
  res_t       mbuf [$];
  logic [4:0] outst [$];   // destinations issued to the long unit, not yet accepted
  bit         offer_active;
  bit         chk_en = 1'b0;

  function automatic bit trk(input logic [4:0] r);
    return (r != 0) && (int'(r) < NREG);
  endfunction

  function automatic void retire(input logic [4:0] r);
    if (trk(r)) mbusy[r] = 1'b0;
    mpend--;
  endfunction

  function automatic void model_clear();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mpend = 0;
    mwait = 0;
    mbuf.delete();
    outst.delete();
    offer_active = 1'b0;
  endfunction

  bit              e_stall, e_ready, e_we, pipe_wr, acc, fire;
  logic [4:0]      e_a3;
  logic [XLEN-1:0] e_wd;
  res_t            ent;

  // Compare outputs against the model, then advance the model one cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      e_we = 1'b0; e_a3 = '0; e_wd = '0;
      pipe_wr = PipeWe && (PipeRd != 0);
      if (reset) begin
        e_stall = 1'b1;
        e_ready = 1'b0;
      end else begin
        e_ready = (mbuf.size() == 0);
        e_stall = (IssueValid && (mbusy[IssueRs1] || mbusy[IssueRs2] || mbusy[IssueRd]))
               || (IssueValid && IssueLong && mpend == MAXP)
               || (mwait >= STV);
        if (pipe_wr) begin
          e_we = 1'b1; e_a3 = PipeRd; e_wd = PipeWd;
        end else if (mbuf.size() > 0) begin
          e_we = 1'b1; e_a3 = mbuf[0].rd; e_wd = mbuf[0].wd;
        end else if (LongValid && LongRd != 0) begin
          e_we = 1'b1; e_a3 = LongRd; e_wd = LongWd;
        end
      end
      chk("m_IssueStall", 64'(IssueStall), 64'(e_stall));
      chk("m_LongReady", 64'(LongReady), 64'(e_ready));
      chk("m_RfWe", 64'(RfWe), 64'(e_we));
      chk("m_RfA3", 64'(RfA3), 64'(e_a3));
      chk("m_RfWd", RfWd, e_wd);

      if (reset) begin
        model_clear();
      end else begin
        acc  = LongValid && e_ready;
        fire = IssueValid && !e_stall;
        if (acc) begin
          for (int i = 0; i < outst.size(); i++) begin
            if (outst[i] == LongRd) begin
              outst.delete(i);
              break;
            end
          end
          offer_active = 1'b0;
        end
        if (pipe_wr) begin
          if (mbuf.size() > 0) mwait++;
          if (acc) begin
            if (LongRd != 0) begin
              ent.rd = LongRd; ent.wd = LongWd;
              mbuf.push_back(ent);
            end else begin
              retire(LongRd);
            end
          end
        end else if (mbuf.size() > 0) begin
          retire(mbuf[0].rd);
          mbuf.delete(0);
          mwait = 0;
        end else if (acc) begin
          retire(LongRd);
        end
        if (fire && IssueLong) begin
          if (trk(IssueRd)) mbusy[IssueRd] = 1'b1;
          mpend++;
          outst.push_back(IssueRd);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IssueValid = 0; IssueLong = 0; IssueRs1 = 0; IssueRs2 = 0; IssueRd = 0;
    PipeWe = 0; PipeRd = 0; PipeWd = 0;
    LongValid = 0; LongRd = 0; LongWd = 0;
  endtask

  task automatic issue(input bit lng, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    IssueValid = 1; IssueLong = lng; IssueRs1 = rs1; IssueRs2 = rs2; IssueRd = rd;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    tick(); tick();
    reset = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  int idx;

  initial begin
    model_clear();
    idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_stall", 64'(IssueStall), 64'd1);
    chk("rst_ready", 64'(LongReady), 64'd0);
    chk("rst_we", 64'(RfWe), 64'd0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("post_rst_stall", 64'(IssueStall), 64'd0);
    chk("post_rst_ready", 64'(LongReady), 64'd1);
    chk("post_rst_we", 64'(RfWe), 64'd0);
    tick();

    // RAW stall on a long destination until its writeback.
    issue(1, 0, 0, 5);
    @(negedge clk); chk("t1_long_fire", 64'(IssueStall), 64'd0); tick();
    issue(0, 5, 0, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t1_raw_stall", 64'(IssueStall), 64'd1); tick();
    end
    LongValid = 1; LongRd = 5; LongWd = 64'h55;
    @(negedge clk);
    chk("t1_wb_we", 64'(RfWe), 64'd1);
    chk("t1_wb_a3", 64'(RfA3), 64'd5);
    chk("t1_wb_cycle_stall", 64'(IssueStall), 64'd1);
    tick();
    LongValid = 0;
    @(negedge clk); chk("t1_after_wb_fire", 64'(IssueStall), 64'd0); tick();

    // Direct zero-latency write when the pipe is idle.
    idle(); issue(1, 0, 0, 7); tick();
    idle(); LongValid = 1; LongRd = 7; LongWd = 64'hAB;
    @(negedge clk);
    chk("t2_we", 64'(RfWe), 64'd1);
    chk("t2_a3", 64'(RfA3), 64'd7);
    chk("t2_wd", RfWd, 64'hAB);
    chk("t2_ready", 64'(LongReady), 64'd1);
    tick();
    LongValid = 0; issue(0, 7, 7, 7);
    @(negedge clk);
    chk("t2_busy_cleared", 64'(IssueStall), 64'd0);
    chk("t2_ready_after", 64'(LongReady), 64'd1);
    tick();

    // Buffering while the pipe owns the port.
    idle(); issue(1, 0, 0, 7); tick();
    idle(); LongValid = 1; LongRd = 7; LongWd = 64'hAB; PipeWe = 1; PipeRd = 3; PipeWd = 64'h33;
    @(negedge clk);
    chk("t3_pipe_a3", 64'(RfA3), 64'd3);
    chk("t3_pipe_wd", RfWd, 64'h33);
    tick();
    LongValid = 0; PipeRd = 4; PipeWd = 64'h44;
    @(negedge clk);
    chk("t3_pipe2_a3", 64'(RfA3), 64'd4);
    chk("t3_ready_full", 64'(LongReady), 64'd0);
    tick();
    PipeWe = 0;
    @(negedge clk);
    chk("t3_drain_we", 64'(RfWe), 64'd1);
    chk("t3_drain_a3", 64'(RfA3), 64'd7);
    chk("t3_drain_wd", RfWd, 64'hAB);
    tick();
    @(negedge clk);
    chk("t3_ready_back", 64'(LongReady), 64'd1);
    chk("t3_idle_we", 64'(RfWe), 64'd0);
    tick();

    // Starvation: bubbles forced once the buffer has waited STARVE cycles.
    idle(); issue(1, 0, 0, 8); tick();
    idle(); LongValid = 1; LongRd = 8; LongWd = 64'h88; PipeWe = 1; PipeRd = 3; tick();
    LongValid = 0; issue(0, 1, 2, 9);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); chk("t4_no_starve", 64'(IssueStall), 64'd0); tick();
    end
    for (int c = 5; c <= 6; c++) begin
      @(negedge clk); chk("t4_starve", 64'(IssueStall), 64'd1); tick();
    end
    PipeWe = 0;
    @(negedge clk);
    chk("t4_drain_stall", 64'(IssueStall), 64'd1);
    chk("t4_drain_a3", 64'(RfA3), 64'd8);
    tick();
    @(negedge clk); chk("t4_wait_cleared", 64'(IssueStall), 64'd0); tick();

    // MAXPEND limit on long issues.
    idle();
    for (int r = 1; r <= 4; r++) begin
      issue(1, 0, 0, 5'(r));
      @(negedge clk); chk("t5_long_fire", 64'(IssueStall), 64'd0); tick();
    end
    issue(1, 0, 0, 10);
    @(negedge clk); chk("t5_pend_full", 64'(IssueStall), 64'd1); tick();
    issue(0, 11, 0, 12);
    @(negedge clk); chk("t5_short_fires", 64'(IssueStall), 64'd0); tick();
    issue(1, 0, 0, 10); LongValid = 1; LongRd = 2; LongWd = 64'h22;
    @(negedge clk);
    chk("t5_complete_cycle", 64'(IssueStall), 64'd1);
    chk("t5_complete_a3", 64'(RfA3), 64'd2);
    tick();
    LongValid = 0;
    @(negedge clk); chk("t5_fires_after", 64'(IssueStall), 64'd0); tick();
    do_reset();

    // Untracked destinations (x20 with E, and x0) still count in pend.
    issue(1, 0, 0, 20);
    @(negedge clk); chk("t6_x20_fire", 64'(IssueStall), 64'd0); tick();
    issue(0, 20, 20, 20);
    @(negedge clk); chk("t6_x20_not_busy", 64'(IssueStall), 64'd0); tick();
    issue(1, 0, 0, 0);  tick();
    issue(1, 0, 0, 20); tick();
    issue(1, 0, 0, 0);  tick();
    issue(1, 0, 0, 21);
    @(negedge clk); chk("t6_pend_counts_untracked", 64'(IssueStall), 64'd1); tick();
    LongValid = 1; LongRd = 0; LongWd = 64'h99;
    @(negedge clk);
    chk("t6_x0_we", 64'(RfWe), 64'd0);
    chk("t6_x0_a3", 64'(RfA3), 64'd0);
    chk("t6_x0_ready", 64'(LongReady), 64'd1);
    tick();
    LongValid = 0;
    @(negedge clk); chk("t6_x0_pend_dec", 64'(IssueStall), 64'd0); tick();
    do_reset();

    // Randomized traffic with a legal upstream long unit and pipe.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      IssueValid = ($urandom_range(0, 9) < 7);
      IssueLong  = ($urandom_range(0, 9) < 4);
      IssueRs1 = pick_reg(); IssueRs2 = pick_reg(); IssueRd = pick_reg();
      PipeWe = ($urandom_range(0, 9) < 6);
      PipeRd = pick_reg();
      if (mbusy[PipeRd]) PipeRd = 0;
      PipeWd = {$urandom, $urandom};
      if (reset) begin
        LongValid = 0;
      end else if (!offer_active) begin
        LongValid = 0;
        if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, outst.size() - 1);
          LongRd = outst[idx];
          LongWd = {$urandom, $urandom};
          LongValid = 1;
          offer_active = 1'b1;
        end
      end
      tick();
    end

    reset = 0; idle(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
